// File: rtl/fb_access_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fb_access_arbiter                                                        |
// | Single-port framebuffer arbiter: scanout reads, frame clear, PPU writes. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fb_access_arbiter #(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [5:0] CLEAR_CODE = 6'h0F
) (
  input  logic       ppu_ctl_clk,
  input  logic       rst,
  input  logic       wr_req,
  input  logic [7:0] wr_x,
  input  logic [7:0] wr_y,
  input  logic [5:0] wr_data,
  output logic       wr_ready,
  input  logic       rd_req,
  input  logic [7:0] rd_x,
  input  logic [7:0] rd_y,
  output logic       rd_valid,
  output logic [5:0] rd_data,
  input  logic       clr_start,
  output logic       clr_busy,
  output logic [7:0] drop_cnt,
  output logic       mem_cs,
  output logic       mem_we,
  output logic [7:0] mem_x,
  output logic [7:0] mem_y,
  output logic [5:0] mem_wdata,
  input  logic [5:0] mem_rdata
);

  localparam int         AW          = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] C_DEPTH    = (AW+1)'(FIFO_DEPTH);
  localparam logic [7:0] C_LAST_X    = 8'd255;
  localparam logic [7:0] C_LAST_Y    = 8'd239;
  localparam logic [0:0] S_IDLE      = 1'b0;
  localparam logic [0:0] S_CLEAR     = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [7:0]  clr_x_q, clr_x_d;
  logic [7:0]  clr_y_q, clr_y_d;
  logic [7:0]  drop_cnt_q, drop_cnt_d;
  logic        rd_valid_q;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic [21:0]   fifo_mem_q [FIFO_DEPTH];

  logic        fifo_full;
  logic        fifo_empty;
  logic        push;
  logic        pop;
  logic [21:0] head;
  logic        head_in_range;
  logic        clear_step;
  logic        clear_last;

  assign clr_busy      = (state_q == S_CLEAR);
  assign fifo_full     = (count_q == C_DEPTH);
  assign fifo_empty    = (count_q == '0);
  assign wr_ready      = !fifo_full && !clr_busy;
  assign push          = wr_req && wr_ready;
  // Reads and the clear sweep both starve the write queue.
  assign pop           = !fifo_empty && !rd_req && !clr_busy;
  assign head          = fifo_mem_q[rptr_q];
  assign head_in_range = (head[13:6] <= C_LAST_Y);
  assign clear_step    = clr_busy && !rd_req;
  assign clear_last    = (clr_x_q == C_LAST_X) && (clr_y_q == C_LAST_Y);

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_valid_q ? mem_rdata : 6'd0;
  assign drop_cnt = drop_cnt_q;

  always_comb begin
    mem_cs    = 1'b0;
    mem_we    = 1'b0;
    mem_x     = 8'd0;
    mem_y     = 8'd0;
    mem_wdata = 6'd0;
    if (rd_req) begin
      mem_cs = 1'b1;
      mem_x  = rd_x;
      mem_y  = rd_y;
    end else if (clear_step) begin
      mem_cs    = 1'b1;
      mem_we    = 1'b1;
      mem_x     = clr_x_q;
      mem_y     = clr_y_q;
      mem_wdata = CLEAR_CODE;
    end else if (pop && head_in_range) begin
      mem_cs    = 1'b1;
      mem_we    = 1'b1;
      mem_x     = head[21:14];
      mem_y     = head[13:6];
      mem_wdata = head[5:0];
    end
  end

  always_comb begin
    state_d = state_q;
    clr_x_d = clr_x_q;
    clr_y_d = clr_y_q;
    case (state_q)
      S_IDLE: begin
        if (clr_start) begin
          state_d = S_CLEAR;
          clr_x_d = 8'd0;
          clr_y_d = 8'd0;
        end
      end
      S_CLEAR: begin
        if (clear_step) begin
          if (clear_last) begin
            state_d = S_IDLE;
            clr_x_d = 8'd0;
            clr_y_d = 8'd0;
          end else begin
            clr_x_d = clr_x_q + 8'd1;
            if (clr_x_q == C_LAST_X) begin
              clr_y_d = clr_y_q + 8'd1;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (pop && !head_in_range && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  // Depth is a power of two, so pointers wrap naturally.
  always_comb begin
    wptr_d  = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = pop  ? rptr_q + 1'b1 : rptr_q;
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge ppu_ctl_clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      clr_x_q    <= 8'd0;
      clr_y_q    <= 8'd0;
      drop_cnt_q <= 8'd0;
      rd_valid_q <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      clr_x_q    <= clr_x_d;
      clr_y_q    <= clr_y_d;
      drop_cnt_q <= drop_cnt_d;
      rd_valid_q <= rd_req;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge ppu_ctl_clk) begin
    if (push) begin
      fifo_mem_q[wptr_q] <= {wr_x, wr_y, wr_data};
    end
  end

endmodule
`default_nettype wire

// File: doc/fb_access_arbiter.md
FB_ACCESS_ARBITER -- requirements
Module: fb_access_arbiter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, PPU write-queue depth (power of 2, 2..16).
REQ-002 SHALL have parameter CLEAR_CODE, default 6'h0F, colour code written by a frame clear.
REQ-003 SHALL have one clock and an asynchronous, active-high reset: ppu_ctl_clk and rst.
REQ-004 ppu_ctl_clk  in  1  sole clock, all state on rising edge.
REQ-005 rst  in  1  async active-high reset.
REQ-006 wr_req  in  1  PPU pixel write request.
REQ-007 wr_x, wr_y  in  8 each  PPU write coordinates.
REQ-008 wr_data  in  6  PPU colour code.
REQ-009 wr_ready  out  1  write accepted this cycle when wr_req & wr_ready.
REQ-010 rd_req  in  1  scanout read request; no backpressure.
REQ-011 rd_x, rd_y  in  8 each  scanout coordinates.
REQ-012 rd_valid  out  1  rd_data valid.
REQ-013 rd_data  out  6  colour code read.
REQ-014 clr_start  in  1  pulse, start full-frame clear.
REQ-015 clr_busy  out  1  clear in progress.
REQ-016 drop_cnt  out  8  saturating count of discarded out-of-range writes.
REQ-017 mem_cs, mem_we  out  1 each  single-port RAM select / write enable.
REQ-018 mem_x, mem_y  out  8 each  RAM address.
REQ-019 mem_wdata  out  6  RAM write data.
REQ-020 mem_rdata  in  6  RAM read data, valid one cycle after a read cycle.

Function
REQ-021 SHALL issue at most one RAM access per cycle; priority: read > clear > queued write.
REQ-022 rd_req in cycle N SHALL drive mem_cs=1, mem_we=0, address rd_x/rd_y in N; rd_valid=1 in N+1 with rd_data=mem_rdata; rd_data SHALL be 0 when rd_valid=0.
REQ-023 Back-to-back rd_req SHALL sustain one read per cycle, fixed latency 1.
REQ-024 wr_ready SHALL be 1 iff queue not full and clr_busy=0; push on wr_req & wr_ready.
REQ-025 Push when full SHALL NOT be accepted, even with a same-cycle pop; queue contents unchanged.
REQ-026 Queue SHALL be FIFO order; head popped only in a cycle with no rd_req and clr_busy=0.
REQ-027 Popped entry with wr_y <= 239 SHALL drive mem_cs=1, mem_we=1, head address/data that cycle.
REQ-028 Popped entry with wr_y > 239 SHALL be discarded with no RAM access; drop_cnt+1, saturating at 255.
REQ-029 States: IDLE, CLEAR. IDLE->CLEAR on clr_start (queue is left intact, not drained); CLEAR->IDLE after write of (255,239).
REQ-030 clr_start while clr_busy=1 SHALL be ignored.
REQ-031 CLEAR SHALL write CLEAR_CODE sweeping x 0..255 inner, y 0..239 outer, one pixel per cycle without rd_req; rd_req cycles stall the sweep, no pixel skipped.
REQ-032 clr_busy SHALL be 1 from the cycle after clr_start through the cycle of the final clear write; 61440 writes total when no reads intervene.
REQ-033 Idle cycles SHALL drive mem_cs=0, mem_we=0.

Reset
REQ-034 rst SHALL immediately force: queue empty, state IDLE, clr_busy=0, rd_valid=0, rd_data=0, drop_cnt=0, mem_cs=0, mem_we=0, clear pointers 0, wr_ready=1 after release.
REQ-035 rst mid-clear SHALL abort the clear; no resume after release.
REQ-036 A read in flight at reset SHALL produce no rd_valid.

Verification
REQ-037 Push (3,5,6'h21),(4,5,6'h22), no reads -> two write cycles in order, then rd_req (4,5) -> rd_valid next cycle, rd_data=6'h22.
REQ-038 rd_req held high 10 cycles while 4 writes pushed -> wr_ready=0 after 4th push, zero mem_we cycles, writes drain in order on first 4 cycles after rd_req drops.
REQ-039 Push (10,240,6'h01) then (10,2,6'h02) -> first discarded, drop_cnt=1, only (10,2) written; 300 such -> drop_cnt=255.
REQ-040 clr_start, no reads -> clr_busy 61440 cycles, last write (255,239)=6'h0F; with rd_req every 2nd cycle -> still 61440 clear writes, none skipped.
REQ-041 rst asserted at clear write 1000 -> clr_busy=0 at once, mem_we=0, no further clear writes; wr_ready=1 after release.
